// File: rtl/out_uart_pkg.sv
// Shared types and constants for the output-port UART streamer.
package out_uart_pkg;

    localparam int unsigned WORD_W               = 16;
    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/out_word_fifo.sv
// Small word FIFO with a count register; simultaneous push and pop both take effect.
module out_word_fifo
    import out_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              push,
    input  logic [WORD_W-1:0] din,
    input  logic              pop,
    output logic [WORD_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/out_uart_streamer.sv
// Queues every change of the output-port word and sends it as two 8N1 bytes, high byte first.
module out_uart_streamer
    import out_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [WORD_W-1:0] Word_in,
    output logic              Tx,
    output logic              Busy,
    output logic              Overflow
);

    localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_sel_q, byte_sel_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] lo_byte_q, lo_byte_d;
    logic              tx_q, tx_d;
    logic [WORD_W-1:0] last_seen_q, last_seen_d;
    logic              overflow_q, overflow_d;

    logic              push, pop, baud_done;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_full;

    out_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .din     (Word_in),
        .pop     (pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // last_seen tracks the input even when the push is dropped.
    always_comb begin
        push        = (Word_in != last_seen_q);
        last_seen_d = push ? Word_in : last_seen_q;
        overflow_d  = overflow_q | (push & fifo_full & ~pop);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        lo_byte_d  = lo_byte_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        baud_done  = (cnt_q == CNT_MAX);

        // tx_d always carries the line level of the state being entered.
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_dout[WORD_W-1:BYTE_W];
                    lo_byte_d  = fifo_dout[BYTE_W-1:0];
                    byte_sel_d = 1'b1;
                    cnt_d      = '0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (byte_sel_q) begin
                        byte_sel_d = 1'b0;
                        shift_d    = lo_byte_q;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_sel_q  <= 1'b0;
            shift_q     <= '0;
            lo_byte_q   <= '0;
            tx_q        <= 1'b1;
            last_seen_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_sel_q  <= byte_sel_d;
            shift_q     <= shift_d;
            lo_byte_q   <= lo_byte_d;
            tx_q        <= tx_d;
            last_seen_q <= last_seen_d;
            overflow_q  <= overflow_d;
        end
    end

    assign Tx       = tx_q;
    assign Busy     = (state_q != IDLE) | ~fifo_empty;
    assign Overflow = overflow_q;

endmodule

// File: doc/out_uart_streamer.md
# out_uart_streamer

Downstream consumer of the processor's 16-bit output port. It watches the registered output word, queues every new value in a small FIFO, and serializes each queued word as two UART 8N1 bytes, high byte first. This lets the board report program results over a serial line without stalling the core.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- DEPTH, default 4: FIFO entries; power of two, ≥ 2.

- Clk  in  1  single clock; all state updates on its rising edge.
- Reset_n  in  1  reset, synchronous and active-low.
- Word_in  in  16  output-port word; driven from a register, so stable between edges.
- Tx  out  1  UART serial line; idle high.
- Busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- Overflow  out  1  sticky; set when a changed word is dropped because the FIFO is full.

## Operation
- Reset (Reset_n = 0 at an edge) sets the following registers:
  - Tx = 1, Busy = 0, Overflow = 0.
  - FIFO empty, last_seen = 16'h0000, FSM in IDLE.
- Change detect:
  - Each edge compares Word_in with last_seen. On a mismatch it pushes Word_in and loads last_seen = Word_in.
  - last_seen updates even when the push is dropped.
  - Zero is not special: after reset, Word_in = 0 sends nothing, but a later change back to 0 is sent.
- FIFO: DEPTH entries with a count register.
  - Push when full and no pop at the same edge: word dropped, Overflow set to 1. Overflow clears only on reset.
  - Push and pop at the same edge: both take effect. This holds when full (push accepted) and when holding one entry.
  - Pop when empty: never occurs.
- Transmit FSM, one state register:
  - IDLE, FIFO non-empty: pop, load the word, byte_sel = high, go to START.
  - START: Tx = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index, then STOP.
  - STOP: Tx = 1 for CLKS_PER_BIT cycles. If byte_sel = high: set byte_sel = low, go to START. Otherwise go to IDLE.
- Tx is a register (no glitches). It is 1 in IDLE and STOP.
- Baud counter counts 0 to CLKS_PER_BIT−1, width $clog2(CLKS_PER_BIT), and clears on every state entry.
- Busy = (state ≠ IDLE) | (count ≠ 0). It is combinational from registers.

## Timing
- Changed word sampled at edge k with the FIFO empty and the FSM in IDLE:
  - Pop at edge k+1.
  - Tx low from edge k+1.
- Word frame length: 20·CLKS_PER_BIT cycles. There is no gap between the high and low bytes.
- Back-to-back queued words have exactly 1 IDLE cycle between the end of one STOP and the next START.
- Sustained throughput: 1 word per 20·CLKS_PER_BIT+1 cycles. Faster change rates overflow after DEPTH+1 unsent words.
- Reset mid-frame: at the reset edge Tx = 1 and the frame is abandoned. The FIFO contents are discarded.
- Reset held low: no pushes, and Tx stays 1.

## Structure
- Shared package out_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the word and byte width localparams (16, 8);
  - the default CLKS_PER_BIT.
- Sub-module out_word_fifo holds the FIFO:
  - ports: Clk, Reset_n, push, din, pop, dout, empty, full;
  - dout is valid combinationally while not empty.
- The top level contains the change detector, FSM, baud counter, shift register and Overflow flag.

## Test plan
Run all scenarios with CLKS_PER_BIT = 4 and DEPTH = 4.
- Reset, Word_in = 0 held for 200 cycles: Tx = 1, Busy = 0 and Overflow = 0 throughout.
- Word_in 0 → 16'hA55A held:
  - Tx low one edge after the sampling edge.
  - Decoded bytes 0xA5 then 0x5A, 80 cycles total.
  - Busy falls after the final stop bit.
- 16'h1234 held for 1000 cycles: exactly one two-byte frame (0x12, 0x34).
- Six distinct values on consecutive edges:
  - Values 1–5 are transmitted in order and value 6 is dropped.
  - Overflow = 1 and stays 1 until reset.
- Reset_n low for one edge during data bit 3 of the high byte:
  - Tx = 1 after that edge.
  - No further frames; FIFO empty; Busy = 0.
- 16'h1234 then 16'h0000 after it is sent: the second frame is 0x00, 0x00.
